bram_port_arbiter: RTL and testbench
====================================

Name: bram_port_arbiter

Overview:
- Two-requester arbiter sharing the single 128-bit BRAM port between the instruction-side and data-side UA_encrypt units.
- Replaces the ad-hoc priority logic in front of bram_memory. Provides a locked grant per transaction, data priority with an instruction starvation bound, a per-transaction timeout, and the encryption-tag sideband.

Parameters:
- ADDR_BITS, 16, BRAM line address width.
- DATA_BITS, 128, BRAM line width.
- MAX_INST_WAIT, 4, number of consecutive data grants an instruction request may be passed over before it is forced through.
- TIMEOUT, 64, cycles a granted transaction may wait for mem_valid before it is aborted.

Ports:
- sys_clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- inst_req  in  1  instruction requester holds high until inst_valid.
- inst_write  in  1  write enable, instruction side.
- inst_addr  in  ADDR_BITS  line address, instruction side.
- inst_wdata  in  DATA_BITS  write data, instruction side.
- inst_rdata  out  DATA_BITS  read data, instruction side.
- inst_valid  out  1  one-cycle completion pulse, instruction side.
- data_req  in  1  data requester holds high until data_valid.
- data_write  in  1  write enable, data side.
- data_addr  in  ADDR_BITS  line address, data side.
- data_wdata  in  DATA_BITS  write data, data side.
- data_wenc  in  1  write-data-is-encrypted tag, data side.
- data_rdata  out  DATA_BITS  read data, data side.
- data_rdata_enc  out  1  read-data-is-encrypted tag, data side.
- data_valid  out  1  one-cycle completion pulse, data side.
- mem_req  out  1  request to BRAM, held for the transaction.
- mem_write  out  1  write enable to BRAM.
- mem_addr  out  ADDR_BITS  line address to BRAM.
- mem_wdata  out  DATA_BITS  write data to BRAM.
- mem_wenc  out  1  encryption tag to BRAM.
- mem_rdata  in  DATA_BITS  read data from BRAM.
- mem_rdata_enc  in  1  encryption tag of the read line.
- mem_valid  in  1  completion pulse from BRAM.
- timeout_err  out  1  sticky; set on any aborted transaction.
- grant_inst  out  1  debug: instruction side currently granted.
- grant_data  out  1  debug: data side currently granted.

Behaviour:
- FSM states: IDLE, GNT_I, GNT_D, RELEASE. On reset: state IDLE; all outputs 0; starve counter 0; timeout counter 0; timeout_err 0.
- IDLE decision, evaluated each cycle:
  - If data_req is high and (inst_req is low or starve < MAX_INST_WAIT): go to GNT_D. Increment starve if inst_req is high; otherwise clear it.
  - Else if inst_req is high: go to GNT_I and clear starve.
  - Simultaneous requests resolve to data unless starve == MAX_INST_WAIT.
- Grant entry: mem_* outputs are registered from the winner's inputs on the transition, so mem_req rises one cycle after the request is seen. Inputs are latched; changes from the requester during the grant are ignored.
- mem_wenc is data_wenc on a data grant and 0 on an instruction grant.
- In GNT_x:
  - mem_req stays high and the timeout counter increments.
  - When mem_valid is high: x_valid is driven combinationally high that same cycle, with x_rdata = mem_rdata (and data_rdata_enc = mem_rdata_enc on the data side). Then go to RELEASE.
  - The non-granted valid stays 0. The rdata outputs hold their last value when not valid.
- Timeout: if the counter reaches TIMEOUT-1 without mem_valid, set timeout_err, pulse x_valid with rdata = 0, and go to RELEASE.
- RELEASE:
  - Lasts exactly 1 cycle with mem_req = 0 and the counter cleared, then returns to IDLE.
  - This guarantees the requester has dropped its req before re-arbitration.
  - Back-to-back throughput is one transaction per (BRAM latency + 3) cycles.
- A mem_valid arriving in IDLE or RELEASE is ignored and produces no valid pulse.
- A requester dropping req mid-grant does not abort the transaction; the completion pulse is still issued.
- Reset mid-transaction: return to IDLE immediately with mem_req = 0; a later stray mem_valid is ignored.
- grant_inst / grant_data equal (state == GNT_I) / (state == GNT_D).

Test Plan:
- Single data read: data_req=1, addr=0x12, BRAM valid 2 cycles after mem_req -> mem_req rises at cycle 1, data_valid pulses at cycle 3 with mem_rdata, mem_req=0 at cycle 4.
- Simultaneous requests with MAX_INST_WAIT=4: data and inst held high, data re-requests after each valid -> 4 data grants, 5th grant goes to inst; starve returns to 0.
- Write tagging: data write with data_wenc=1 -> mem_wenc=1; instruction write -> mem_wenc=0; data read with mem_rdata_enc=1 -> data_rdata_enc=1 on the valid cycle.
- Timeout with TIMEOUT=64: grant data, never assert mem_valid -> data_valid pulses with rdata=0 at cycle 64 of the grant; timeout_err=1 and stays 1; next inst request is served normally.
- Reset during GNT_I: assert reset, then deliver mem_valid -> inst_valid stays 0, state IDLE, all outputs 0.
- Stray mem_valid in IDLE -> no valid pulse on either side and no state change.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter
//
// Shares the single BRAM line port between the instruction-side and data-side
// UA_encrypt units. One transaction is in flight at a time, and the winner's
// request is latched for the whole grant. Data requests have priority, but an
// instruction request can only be passed over MAX_INST_WAIT times in a row.
// A grant that sees no mem_valid within TIMEOUT cycles is aborted: the
// requester still gets its completion pulse, with zero read data, and
// timeout_err is set.
//
// Ports
//   sys_clock, reset          clock; synchronous active-high reset
//   inst_req/write/addr/wdata instruction requester (req held until inst_valid)
//   inst_rdata, inst_valid    instruction completion (valid is a 1-cycle pulse)
//   data_req/write/addr/wdata data requester (req held until data_valid)
//   data_wenc                 write-data-is-encrypted tag
//   data_rdata(_enc), data_valid  data completion and read tag
//   mem_req/write/addr/wdata/wenc  registered request to BRAM
//   mem_rdata(_enc), mem_valid     BRAM response
//   timeout_err               sticky abort flag
//   grant_inst, grant_data    debug view of the current grant
// -----------------------------------------------------------------------------
module bram_port_arbiter #(
   parameter int ADDR_BITS     = 16,
   parameter int DATA_BITS     = 128,
   parameter int MAX_INST_WAIT = 4,
   parameter int TIMEOUT       = 64
) (
   input  logic                 sys_clock,
   input  logic                 reset,
   input  logic                 inst_req,
   input  logic                 inst_write,
   input  logic [ADDR_BITS-1:0] inst_addr,
   input  logic [DATA_BITS-1:0] inst_wdata,
   output logic [DATA_BITS-1:0] inst_rdata,
   output logic                 inst_valid,
   input  logic                 data_req,
   input  logic                 data_write,
   input  logic [ADDR_BITS-1:0] data_addr,
   input  logic [DATA_BITS-1:0] data_wdata,
   input  logic                 data_wenc,
   output logic [DATA_BITS-1:0] data_rdata,
   output logic                 data_rdata_enc,
   output logic                 data_valid,
   output logic                 mem_req,
   output logic                 mem_write,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [DATA_BITS-1:0] mem_wdata,
   output logic                 mem_wenc,
   input  logic [DATA_BITS-1:0] mem_rdata,
   input  logic                 mem_rdata_enc,
   input  logic                 mem_valid,
   output logic                 timeout_err,
   output logic                 grant_inst,
   output logic                 grant_data
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] GNT_I   = 2'd1;
   localparam logic [1:0] GNT_D   = 2'd2;
   localparam logic [1:0] RELEASE = 2'd3;

   localparam int STARVE_BITS = $clog2(MAX_INST_WAIT + 1);
   localparam int TMO_BITS    = $clog2(TIMEOUT + 1);

   localparam logic [STARVE_BITS-1:0] STARVE_MAX = STARVE_BITS'(MAX_INST_WAIT);
   localparam logic [TMO_BITS-1:0]    TMO_LAST   = TMO_BITS'(TIMEOUT - 1);

   logic [1:0]             state_reg, state_next;
   logic [STARVE_BITS-1:0] starve_reg, starve_next;
   logic [TMO_BITS-1:0]    tmo_reg, tmo_next;
   logic                   timeout_err_reg, timeout_err_next;
   logic                   mem_req_reg, mem_req_next;
   logic                   mem_write_reg, mem_write_next;
   logic [ADDR_BITS-1:0]   mem_addr_reg, mem_addr_next;
   logic [DATA_BITS-1:0]   mem_wdata_reg, mem_wdata_next;
   logic                   mem_wenc_reg, mem_wenc_next;

   // A grant finishes either on mem_valid or on the last timeout cycle.
   // mem_valid wins if both occur together. Reset suppresses the pulse so a
   // transaction being reset never reports completion.
   logic in_grant;
   logic tmo_hit;
   logic finish;
   logic [DATA_BITS-1:0] rd_value;
   logic                 rd_enc_value;
   logic [1:0]           side_valid;   // [0] instruction, [1] data

   assign in_grant     = (state_reg == GNT_I) || (state_reg == GNT_D);
   assign tmo_hit      = (tmo_reg == TMO_LAST);
   assign finish       = in_grant && !reset && (mem_valid || tmo_hit);
   assign rd_value     = mem_valid ? mem_rdata : '0;
   assign rd_enc_value = mem_valid ? mem_rdata_enc : 1'b0;
   assign side_valid   = {finish && (state_reg == GNT_D),
                          finish && (state_reg == GNT_I)};

   always_comb begin
      state_next       = state_reg;
      starve_next      = starve_reg;
      tmo_next         = tmo_reg;
      timeout_err_next = timeout_err_reg;
      mem_req_next     = mem_req_reg;
      mem_write_next   = mem_write_reg;
      mem_addr_next    = mem_addr_reg;
      mem_wdata_next   = mem_wdata_reg;
      mem_wenc_next    = mem_wenc_reg;

      case (state_reg)
         IDLE: begin
            tmo_next = '0;
            if (data_req && (!inst_req || (starve_reg < STARVE_MAX))) begin
               state_next     = GNT_D;
               starve_next    = inst_req ? starve_reg + 1'b1 : '0;
               mem_req_next   = 1'b1;
               mem_write_next = data_write;
               mem_addr_next  = data_addr;
               mem_wdata_next = data_wdata;
               mem_wenc_next  = data_wenc;
            end else if (inst_req) begin
               state_next     = GNT_I;
               starve_next    = '0;
               mem_req_next   = 1'b1;
               mem_write_next = inst_write;
               mem_addr_next  = inst_addr;
               mem_wdata_next = inst_wdata;
               mem_wenc_next  = 1'b0;
            end
         end
         GNT_I, GNT_D: begin
            if (mem_valid) begin
               state_next   = RELEASE;
               mem_req_next = 1'b0;
               tmo_next     = '0;
            end else if (tmo_hit) begin
               state_next       = RELEASE;
               mem_req_next     = 1'b0;
               tmo_next         = '0;
               timeout_err_next = 1'b1;
            end else begin
               tmo_next = tmo_reg + 1'b1;
            end
         end
         default: begin
            // RELEASE: one dead cycle so the requester has dropped req before
            // the next arbitration.
            state_next   = IDLE;
            mem_req_next = 1'b0;
            tmo_next     = '0;
         end
      endcase
   end

   always_ff @(posedge sys_clock) begin
      if (reset) begin
         state_reg       <= IDLE;
         starve_reg      <= '0;
         tmo_reg         <= '0;
         timeout_err_reg <= 1'b0;
         mem_req_reg     <= 1'b0;
         mem_write_reg   <= 1'b0;
         mem_addr_reg    <= '0;
         mem_wdata_reg   <= '0;
         mem_wenc_reg    <= 1'b0;
      end else begin
         state_reg       <= state_next;
         starve_reg      <= starve_next;
         tmo_reg         <= tmo_next;
         timeout_err_reg <= timeout_err_next;
         mem_req_reg     <= mem_req_next;
         mem_write_reg   <= mem_write_next;
         mem_addr_reg    <= mem_addr_next;
         mem_wdata_reg   <= mem_wdata_next;
         mem_wenc_reg    <= mem_wenc_next;
      end
   end

   // Per-side read data: shows the live value on the completion cycle and
   // holds it afterwards.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_side
         logic [DATA_BITS-1:0] hold_reg;
         always_ff @(posedge sys_clock) begin
            if (reset) begin
               hold_reg <= '0;
            end else if (side_valid[gi]) begin
               hold_reg <= rd_value;
            end
         end
      end
   endgenerate

   logic data_enc_hold_reg;
   always_ff @(posedge sys_clock) begin
      if (reset) begin
         data_enc_hold_reg <= 1'b0;
      end else if (side_valid[1]) begin
         data_enc_hold_reg <= rd_enc_value;
      end
   end

   assign inst_valid     = side_valid[0];
   assign data_valid     = side_valid[1];
   assign inst_rdata     = side_valid[0] ? rd_value : g_side[0].hold_reg;
   assign data_rdata     = side_valid[1] ? rd_value : g_side[1].hold_reg;
   assign data_rdata_enc = side_valid[1] ? rd_enc_value : data_enc_hold_reg;

   assign mem_req     = mem_req_reg;
   assign mem_write   = mem_write_reg;
   assign mem_addr    = mem_addr_reg;
   assign mem_wdata   = mem_wdata_reg;
   assign mem_wenc    = mem_wenc_reg;
   assign timeout_err = timeout_err_reg;
   assign grant_inst  = (state_reg == GNT_I);
   assign grant_data  = (state_reg == GNT_D);

endmodule

// File: tb/tb_bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_port_arbiter
//
// Bench for bram_port_arbiter: table of single transactions, then hand-written
// sequences for arbitration fairness, timeout, reset mid-grant and stray
// mem_valid. Expected completions go into a queue when a request is driven and
// are popped when the DUT pulses valid.
// -----------------------------------------------------------------------------
module tb_bram_port_arbiter;

   logic         sys_clock = 1'b0;
   logic         reset;
   logic         inst_req, inst_write;
   logic [15:0]  inst_addr;
   logic [127:0] inst_wdata, inst_rdata;
   logic         inst_valid;
   logic         data_req, data_write, data_wenc;
   logic [15:0]  data_addr;
   logic [127:0] data_wdata, data_rdata;
   logic         data_rdata_enc, data_valid;
   logic         mem_req, mem_write, mem_wenc;
   logic [15:0]  mem_addr;
   logic [127:0] mem_wdata, mem_rdata;
   logic         mem_rdata_enc, mem_valid;
   logic         timeout_err, grant_inst, grant_data;

   int checks = 0;
   int errors = 0;

   always #5 sys_clock = ~sys_clock;

   bram_port_arbiter #(
      .ADDR_BITS(16), .DATA_BITS(128), .MAX_INST_WAIT(4), .TIMEOUT(64)
   ) dut (
      .sys_clock(sys_clock), .reset(reset),
      .inst_req(inst_req), .inst_write(inst_write), .inst_addr(inst_addr),
      .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_valid(inst_valid),
      .data_req(data_req), .data_write(data_write), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_wenc(data_wenc), .data_rdata(data_rdata),
      .data_rdata_enc(data_rdata_enc), .data_valid(data_valid),
      .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wenc(mem_wenc), .mem_rdata(mem_rdata),
      .mem_rdata_enc(mem_rdata_enc), .mem_valid(mem_valid),
      .timeout_err(timeout_err), .grant_inst(grant_inst), .grant_data(grant_data)
   );

   typedef struct {
      logic         side;        // 0 instruction, 1 data
      logic         write;
      logic [15:0]  addr;
      logic [127:0] wdata;
      logic         wenc;        // driven on data_wenc for both sides
      int           lat;         // cycles from mem_req rise to mem_valid (>=1)
      logic [127:0] mrdata;
      logic         menc;
      logic         exp_mem_wenc;
      logic [127:0] exp_rdata;
      logic         exp_renc;
   } vec_t;

   typedef struct {
      logic         side;
      logic [127:0] rdata;
      logic         renc;
   } exp_t;

   vec_t vecs[6];
   exp_t exp_q[$];

   task automatic chk_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Waits up to 'limit' negedges for mem_req; returns the index of the
   // negedge it was seen on, or -1.
   task automatic wait_mem_req(input int limit, output int seen);
      seen = -1;
      for (int k = 0; k < limit; k++) begin
         @(negedge sys_clock);
         if (mem_req) begin
            seen = k;
            break;
         end
      end
      if (seen < 0) begin
         errors++;
         checks++;
         $display("FAIL mem_req_wait: got no mem_req expected mem_req within %0d cycles", limit);
      end
   endtask

   task automatic run_txn(input vec_t v);
      int   seen;
      exp_t e;
      @(posedge sys_clock); #1;
      if (v.side) begin
         data_req = 1'b1; data_write = v.write; data_addr = v.addr; data_wdata = v.wdata;
      end else begin
         inst_req = 1'b1; inst_write = v.write; inst_addr = v.addr; inst_wdata = v.wdata;
      end
      data_wenc = v.wenc;
      exp_q.push_back('{side: v.side, rdata: v.exp_rdata, renc: v.exp_renc});
      wait_mem_req(16, seen);
      if (seen < 0) return;
      chk_vec("grant_latency", 128'(seen), 128'(1));
      chk_bit("grant_side", grant_data, v.side);
      // Requester changes its inputs mid-grant; the latched request must hold.
      inst_addr = ~v.addr; data_addr = ~v.addr; inst_wdata = ~v.wdata; data_wdata = ~v.wdata;
      inst_write = ~v.write; data_write = ~v.write; data_wenc = ~v.wenc;
      repeat (v.lat) @(posedge sys_clock);
      #1;
      mem_valid = 1'b1; mem_rdata = v.mrdata; mem_rdata_enc = v.menc;
      @(negedge sys_clock);
      chk_vec("mem_addr", 128'(mem_addr), 128'(v.addr));
      chk_vec("mem_wdata", mem_wdata, v.wdata);
      chk_bit("mem_write", mem_write, v.write);
      chk_bit("mem_wenc", mem_wenc, v.exp_mem_wenc);
      if ((v.side ? data_valid : inst_valid) !== 1'b1) begin
         chk_bit("valid_pulse", 1'b0, 1'b1);
      end else begin
         e = exp_q.pop_front();
         chk_bit("valid_side", v.side, e.side);
         chk_vec("rdata", v.side ? data_rdata : inst_rdata, e.rdata);
         if (v.side) chk_bit("rdata_enc", data_rdata_enc, e.renc);
      end
      chk_bit("other_valid", v.side ? inst_valid : data_valid, 1'b0);
      @(posedge sys_clock); #1;
      mem_valid = 1'b0; mem_rdata = '1; mem_rdata_enc = 1'b0;
      inst_req = 1'b0; data_req = 1'b0;
      @(negedge sys_clock);
      chk_bit("release_mem_req", mem_req, 1'b0);
      chk_bit("release_valid", inst_valid | data_valid, 1'b0);
      chk_vec("rdata_hold", v.side ? data_rdata : inst_rdata, v.exp_rdata);
      exp_q.delete();
   endtask

   initial begin
      int seen;
      int gc;
      logic exp_side;
      exp_t e;
      logic sides[$];

      vecs[0] = '{1'b1, 1'b0, 16'h0012, 128'h0, 1'b0, 2,
                  128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 1'b0,
                  1'b0, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 16'h00A0, 128'hCAFE_0001, 1'b1, 1,
                  128'h1, 1'b0, 1'b1, 128'h1, 1'b0};
      vecs[2] = '{1'b0, 1'b1, 16'h0B0B, 128'h1234_5678, 1'b1, 3,
                  128'h2, 1'b0, 1'b0, 128'h2, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 16'hFFFF, 128'h0, 1'b0, 2,
                  128'h5555_AAAA_5555_AAAA, 1'b1, 1'b0, 128'h5555_AAAA_5555_AAAA, 1'b1};
      vecs[4] = '{1'b0, 1'b0, 16'h0040, 128'h0, 1'b0, 1,
                  128'h0F0F_0F0F, 1'b1, 1'b0, 128'h0F0F_0F0F, 1'b0};
      vecs[5] = '{1'b0, 1'b0, 16'h7777, 128'h0, 1'b0, 5,
                  {4{32'h89AB_CDEF}}, 1'b0, 1'b0, {4{32'h89AB_CDEF}}, 1'b0};

      reset = 1'b1;
      inst_req = 0; inst_write = 0; inst_addr = 0; inst_wdata = 0;
      data_req = 0; data_write = 0; data_addr = 0; data_wdata = 0; data_wenc = 0;
      mem_rdata = 0; mem_rdata_enc = 0; mem_valid = 0;
      repeat (3) @(posedge sys_clock);
      #1 reset = 1'b0;
      @(negedge sys_clock);
      chk_bit("reset_mem_req", mem_req, 1'b0);
      chk_bit("reset_timeout_err", timeout_err, 1'b0);
      chk_bit("reset_grants", grant_inst | grant_data, 1'b0);
      chk_vec("reset_rdata", inst_rdata | data_rdata, 128'h0);
      $display("reset: mem_req=%b timeout_err=%b", mem_req, timeout_err);

      for (int i = 0; i < 6; i++) begin
         run_txn(vecs[i]);
         $display("txn %0d: side=%0d write=%0d addr=%h rdata=%h", i, vecs[i].side,
                  vecs[i].write, vecs[i].addr, vecs[i].side ? data_rdata : inst_rdata);
      end

      // Both requesters held high: four data grants, then instruction, then data.
      sides = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      @(posedge sys_clock); #1;
      data_req = 1; data_write = 0; data_addr = 16'h0D00;
      inst_req = 1; inst_write = 0; inst_addr = 16'h0100;
      for (int g = 0; g < 6; g++) begin
         exp_side = sides.pop_front();
         exp_q.push_back('{side: exp_side, rdata: 128'(g + 100), renc: 1'b0});
         wait_mem_req(10, seen);
         if (seen < 0) break;
         chk_bit("fair_grant_data", grant_data, exp_side);
         @(posedge sys_clock); #1;
         mem_valid = 1; mem_rdata = 128'(g + 100);
         @(negedge sys_clock);
         e = exp_q.pop_front();
         chk_bit("fair_inst_valid", inst_valid, ~e.side);
         chk_bit("fair_data_valid", data_valid, e.side);
         chk_vec("fair_rdata", e.side ? data_rdata : inst_rdata, e.rdata);
         $display("fair grant %0d: grant_data=%b inst_valid=%b data_valid=%b",
                  g, e.side, inst_valid, data_valid);
         @(posedge sys_clock); #1;
         mem_valid = 0;
      end
      inst_req = 0; data_req = 0;
      exp_q.delete();
      repeat (2) @(negedge sys_clock);

      // Timeout: data read that never sees mem_valid.
      @(posedge sys_clock); #1;
      data_req = 1; data_write = 0; data_addr = 16'h0123;
      wait_mem_req(10, seen);
      gc = 1;
      while (gc <= 70 && !data_valid) begin
         chk_bit("tmo_no_inst_valid", inst_valid, 1'b0);
         @(negedge sys_clock);
         gc++;
      end
      chk_vec("tmo_cycle", 128'(gc), 128'(64));
      chk_vec("tmo_rdata", data_rdata, 128'h0);
      $display("timeout: data_valid at grant cycle %0d rdata=%h", gc, data_rdata);
      @(posedge sys_clock); #1;
      data_req = 0;
      @(negedge sys_clock);
      chk_bit("tmo_err_set", timeout_err, 1'b1);
      chk_bit("tmo_release", mem_req, 1'b0);
      run_txn(vecs[4]);
      chk_bit("tmo_err_sticky", timeout_err, 1'b1);
      $display("post-timeout inst txn: inst_rdata=%h timeout_err=%b", inst_rdata, timeout_err);

      // Reset during an instruction grant, then a late mem_valid.
      @(posedge sys_clock); #1;
      inst_req = 1; inst_write = 0; inst_addr = 16'h0456;
      wait_mem_req(10, seen);
      chk_bit("rst_grant_inst", grant_inst, 1'b1);
      @(posedge sys_clock); #1;
      reset = 1;
      @(posedge sys_clock); #1;
      reset = 0; inst_req = 0;
      mem_valid = 1; mem_rdata = 128'hBAD;
      @(negedge sys_clock);
      chk_bit("rst_inst_valid", inst_valid, 1'b0);
      chk_bit("rst_grant", grant_inst | grant_data, 1'b0);
      chk_bit("rst_mem_req", mem_req, 1'b0);
      chk_bit("rst_timeout_err", timeout_err, 1'b0);
      chk_vec("rst_rdata", inst_rdata, 128'h0);
      $display("reset mid-grant: inst_valid=%b mem_req=%b", inst_valid, mem_req);
      @(posedge sys_clock); #1;
      mem_valid = 0;

      // Stray mem_valid while idle.
      @(posedge sys_clock); #1;
      mem_valid = 1; mem_rdata = 128'h5A5A;
      @(negedge sys_clock);
      chk_bit("stray_valid", inst_valid | data_valid, 1'b0);
      @(posedge sys_clock); #1;
      mem_valid = 0;
      @(negedge sys_clock);
      chk_bit("stray_state", grant_inst | grant_data | mem_req, 1'b0);
      chk_vec("stray_rdata", data_rdata, 128'h0);
      $display("stray mem_valid: valids=%b%b mem_req=%b", inst_valid, data_valid, mem_req);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
